counter_bank_mod: RTL
=====================

// Module: counter_bank_mod
// PURPOSE
//  Bank of CHANNELS independent loadable modulo counters. Each counter has a per-channel reset value,
//  a terminal limit, an up/down mode and a parallel load. Replaces single-register enable flops in the
//  lab datapaths: a terminal-count pulse, a sticky flag and a saturating event counter mark each wrap
//  in hardware, so no simulation-only notify hook is needed.
// PARAMETERS
//  WIDTH     16  bits per counter (>=2)
//  CHANNELS  4   number of independent counters (>=1)
//  EVT_W     8   bits of each saturating terminal-event counter (>=1)
// PORTS
//  clk        in   1               rising-edge clock
//  reset      in   1               asynchronous, active-high
//  starting   in   CHANNELS*WIDTH  per-channel value forced into count while reset=1; ch i = [i*WIDTH +: WIDTH]
//  limit      in   CHANNELS*WIDTH  per-channel terminal value (same slicing)
//  dir        in   CHANNELS        per channel: 0=count up, 1=count down
//  en         in   CHANNELS        per-channel count enable
//  load       in   CHANNELS        per-channel synchronous load strobe
//  load_val   in   CHANNELS*WIDTH  value taken on load
//  tc_clear   in   CHANNELS        clears tc_sticky[i] and evt_cnt[i]
//  count_out  out  CHANNELS*WIDTH  current counter values
//  tc_pulse   out  CHANNELS        1-cycle terminal-count strobe
//  tc_sticky  out  CHANNELS        latched terminal-count flag
//  evt_cnt    out  CHANNELS*EVT_W  saturating count of terminal events; ch i = [i*EVT_W +: EVT_W]
//  any_tc     out  1               OR of tc_pulse (registered with it)
// BEHAVIOUR
//  Reset: while reset=1, count_out[i]=starting[i] (combinationally follows starting); tc_pulse=0,
//   tc_sticky=0, evt_cnt=0, any_tc=0. First update is at the first rising clk edge after reset falls.
//  Per channel, evaluated each rising edge; priority is load > en > hold:
//   load=1          : count <= load_val; no terminal event (en ignored).
//   en=1, dir=0 (up): count>=limit -> count <= 0 and terminal event; else count <= count+1.
//   en=1, dir=1 (dn): count==0     -> count <= limit and terminal event; else count <= count-1.
//   en=0, load=0    : hold; no event.
//  Out-of-range start (count>limit):
//   up: wraps to 0 on the next enabled edge, with an event.
//   down: decrements normally until it reaches 0.
//  limit=0: count stays 0; every enabled edge is a terminal event (both directions).
//  dir or limit changing mid-count: takes effect at the next edge; no restart of the count.
//  Terminal event, registered (visible the cycle after the edge, together with the wrapped count):
//   tc_pulse[i]=1 for exactly that cycle; otherwise 0. Back-to-back events give a continuous high.
//   tc_sticky[i] <= 1 on an event; <= 0 on tc_clear without an event.
//   Event and tc_clear on the same edge: sticky=1, evt_cnt=1.
//   evt_cnt[i] += 1 per event, saturating at 2^EVT_W-1. tc_clear alone -> 0.
//  Channels are fully independent; no cross-channel ordering or arbitration.
//  Latency: count_out and all flags update 1 clk after the controlling edge. No combinational
//   input->output paths except starting->count_out during reset.
//  Reset mid-operation: all state is abandoned immediately (async). count_out=starting and flags clear
//   within the same delta; no pending tc_pulse survives.
// TESTING
//  1. reset=1, starting ch0=0x0005; drop reset, en=0 for 3 clks -> count_out ch0 holds 0x0005, tc_pulse=0.
//  2. ch0 up, limit=3, start=0, en=1 for 5 clks -> counts 1,2,3,0,1; tc_pulse[0]=1 only with the 0;
//     evt_cnt[0]=1; tc_sticky[0]=1.
//  3. ch1 down, limit=2, start=1, en=1 -> counts 0,2,1,0,2; tc_pulse[1] high with each 2; load=1 with
//     en=1, load_val=0x00AA -> count=0x00AA, no tc_pulse.
//  4. EVT_W=2, ch2 limit=0, en=1 for 6 clks -> tc_pulse[2] stays high; evt_cnt[2] = 1,2,3,3,3,3; assert
//     tc_clear on the 4th event edge -> sticky=1, evt_cnt=1.
//  5. ch3 up, start=0x0010, limit=0x0008 -> first enabled edge: count=0, tc_pulse[3]=1. Other channels
//     unaffected; any_tc=1 that cycle only.
//  6. Assert reset async mid-count (ch0 at 2, tc pending) -> count_out=starting and all flags 0 before
//     the next clk edge.

Source files
------------

// File: rtl/counter_bank_mod.sv
// counter_bank_mod: a bank of independent loadable modulo counters.
// Each channel counts up or down between 0 and its limit. A wrap is a terminal event.
// Every terminal event produces a one-cycle pulse, sets a sticky flag and increments
// a saturating event counter.
module counter_bank_mod #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int EVT_W    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] starting,
    input  logic [CHANNELS*WIDTH-1:0] limit,
    input  logic [CHANNELS-1:0]       dir,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] load_val,
    input  logic [CHANNELS-1:0]       tc_clear,
    output logic [CHANNELS*WIDTH-1:0] count_out,
    output logic [CHANNELS-1:0]       tc_pulse,
    output logic [CHANNELS-1:0]       tc_sticky,
    output logic [CHANNELS*EVT_W-1:0] evt_cnt,
    output logic                      any_tc
);

    localparam logic [EVT_W-1:0] EVT_MAX = '1;

    logic [WIDTH-1:0]    count_q [CHANNELS];
    logic [WIDTH-1:0]    count_d [CHANNELS];
    logic [EVT_W-1:0]    evt_q   [CHANNELS];
    logic [EVT_W-1:0]    evt_d   [CHANNELS];
    logic [CHANNELS-1:0] tc_event;
    logic [CHANNELS-1:0] tc_pulse_q;
    logic [CHANNELS-1:0] sticky_q;
    logic [CHANNELS-1:0] sticky_d;
    logic                any_tc_q;

    // Next count and terminal-event detection per channel: load beats enable beats hold.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
            count_d[i]  = count_q[i];
            tc_event[i] = 1'b0;
            if (load[i]) begin
                count_d[i] = load_val[i*WIDTH +: WIDTH];
            end else if (en[i]) begin
                if (!dir[i]) begin
                    // ">=" also wraps a count that started above the limit.
                    if (count_q[i] >= limit[i*WIDTH +: WIDTH]) begin
                        count_d[i]  = '0;
                        tc_event[i] = 1'b1;
                    end else begin
                        count_d[i] = count_q[i] + WIDTH'(1);
                    end
                end else begin
                    if (count_q[i] == '0) begin
                        count_d[i]  = limit[i*WIDTH +: WIDTH];
                        tc_event[i] = 1'b1;
                    end else begin
                        count_d[i] = count_q[i] - WIDTH'(1);
                    end
                end
            end
        end
    end

    // Sticky flag and saturating event counter. When an event and a clear arrive on
    // the same edge, the clear takes effect first and the event is then counted.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            sticky_d[i] = sticky_q[i];
            evt_d[i]    = evt_q[i];
            if (tc_event[i]) begin
                sticky_d[i] = 1'b1;
                if (tc_clear[i]) begin
                    evt_d[i] = EVT_W'(1);
                end else if (evt_q[i] != EVT_MAX) begin
                    evt_d[i] = evt_q[i] + EVT_W'(1);
                end
            end else if (tc_clear[i]) begin
                sticky_d[i] = 1'b0;
                evt_d[i]    = '0;
            end
        end
    end

    // Counter registers. While reset is held they track the per-channel starting value,
    // so counting resumes from it on the first edge after release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i] <= starting[i*WIDTH +: WIDTH];
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i] <= count_d[i];
            end
        end
    end

    // Terminal-event flag registers, cleared asynchronously so no pending pulse survives reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tc_pulse_q <= '0;
            sticky_q   <= '0;
            any_tc_q   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                evt_q[i] <= '0;
            end
        end else begin
            tc_pulse_q <= tc_event;
            sticky_q   <= sticky_d;
            any_tc_q   <= |tc_event;
            for (int i = 0; i < CHANNELS; i++) begin
                evt_q[i] <= evt_d[i];
            end
        end
    end

    // Output packing. During reset, count_out follows starting combinationally.
    always_comb begin
        count_out = starting;
        evt_cnt   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!reset) begin
                count_out[i*WIDTH +: WIDTH] = count_q[i];
            end
            evt_cnt[i*EVT_W +: EVT_W] = evt_q[i];
        end
    end

    assign tc_pulse  = tc_pulse_q;
    assign tc_sticky = sticky_q;
    assign any_tc    = any_tc_q;

endmodule
